phy_init_seq: RTL and testbench

//  MDIO init sequencer directly upstream of the PHY register write engine; both run on the same i_mdc (16x-divided) clock.

---
 rtl/phy_init_seq_if.sv | 38 +++
 rtl/phy_init_seq.sv | 194 +++++++++++++++++++
 tb/tb_phy_init_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/phy_init_seq_if.sv
// phy_init_seq_if: bundles the sequencer's handshake with the PHY register
// write engine and its control/status lines to the MAC/DHCP top level.
// The master modport is the sequencer side; slave is the engine/top side.
interface phy_init_seq_if;
    logic        i_start;
    logic        i_write_done;
    logic        o_write_en;
    logic [4:0]  o_phy_ad;
    logic [4:0]  o_phyreg_ad;
    logic [15:0] o_phy_data;
    logic        o_busy;
    logic        o_init_done;
    logic        o_err;

    modport master (
        input  i_start,
        input  i_write_done,
        output o_write_en,
        output o_phy_ad,
        output o_phyreg_ad,
        output o_phy_data,
        output o_busy,
        output o_init_done,
        output o_err
    );

    modport slave (
        output i_start,
        output i_write_done,
        input  o_write_en,
        input  o_phy_ad,
        input  o_phyreg_ad,
        input  o_phy_data,
        input  o_busy,
        input  o_init_done,
        input  o_err
    );
endinterface

// File: rtl/phy_init_seq.sv
// phy_init_seq: MDIO init sequencer. After a power-up wait it issues a fixed
// three-entry table of PHY register writes to the write engine, one at a time,
// holding o_write_en until the engine's done pulse, then flags init complete.
// Re-runnable from the power-up wait on a rising edge of i_start.
// Optional feature: define PHY_INIT_TIMEOUT_EN to abort a write that sees no
// done pulse within TIMEOUT_CYC cycles (goes to ERR with o_err set).
module phy_init_seq #(
    parameter logic [4:0]  PHY_AD      = 5'h01,
    parameter logic [15:0] PWRUP_CYC   = 16'd2000,
    parameter logic [7:0]  GAP_CYC     = 8'd4,
    parameter logic [15:0] RST_WAIT    = 16'd1000,
    parameter logic [4:0]  E0_REG      = 5'h00,
    parameter logic [15:0] E0_DATA     = 16'h8000,
    parameter logic [4:0]  E1_REG      = 5'h04,
    parameter logic [15:0] E1_DATA     = 16'h01E1,
    parameter logic [4:0]  E2_REG      = 5'h00,
`ifdef PHY_INIT_TIMEOUT_EN
    parameter logic [15:0] TIMEOUT_CYC = 16'd255,
`endif
    parameter logic [15:0] E2_DATA     = 16'h1200
) (
    input  logic                  i_mdc,
    input  logic                  i_rst_n,
    phy_init_seq_if.master        bus
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_WRITE,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    // Terminal counts; the gap after entry 0 also covers the soft-reset settle time.
    localparam logic [15:0] PWRUP_LAST = PWRUP_CYC - 16'd1;
    localparam logic [16:0] GAP_LAST_E0 = {9'd0, GAP_CYC} + {1'b0, RST_WAIT} - 17'd1;
    localparam logic [16:0] GAP_LAST    = {9'd0, GAP_CYC} - 17'd1;
`ifdef PHY_INIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYC - 16'd1;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        start_q;
    logic        write_en_q, write_en_d;
    logic [4:0]  phy_ad_q, phy_ad_d;
    logic [4:0]  phyreg_ad_q, phyreg_ad_d;
    logic [15:0] phy_data_q, phy_data_d;
    logic        busy_q, busy_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic        start_rise;

    function automatic logic [4:0] tbl_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    tbl_reg = E0_REG;
            2'd1:    tbl_reg = E1_REG;
            default: tbl_reg = E2_REG;
        endcase
    endfunction

    function automatic logic [15:0] tbl_data(input logic [1:0] idx);
        case (idx)
            2'd0:    tbl_data = E0_DATA;
            2'd1:    tbl_data = E1_DATA;
            default: tbl_data = E2_DATA;
        endcase
    endfunction

    assign start_rise = bus.i_start & ~start_q;

    // Next-state and next-output decode; a start edge overrides everything else.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        idx_d       = idx_q;
        write_en_d  = write_en_q;
        phy_ad_d    = phy_ad_q;
        phyreg_ad_d = phyreg_ad_q;
        phy_data_d  = phy_data_q;
        init_done_d = init_done_q;
        err_d       = err_q;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = 16'd0;
                end
            end
            S_LOAD: begin
                // Address/data settle one cycle ahead of the enable.
                phy_ad_d    = PHY_AD;
                phyreg_ad_d = tbl_reg(idx_q);
                phy_data_d  = tbl_data(idx_q);
                state_d     = S_WRITE;
                cnt_d       = 16'd0;
            end
            S_WRITE: begin
                write_en_d = 1'b1;
                // Only a done seen while enabled belongs to our frame; drop the
                // enable on the very next edge so the engine cannot re-arm.
                if (write_en_q && bus.i_write_done) begin
                    write_en_d = 1'b0;
                    state_d    = S_GAP;
                    cnt_d      = 16'd0;
                end
`ifdef PHY_INIT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    write_en_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERR;
                    cnt_d      = 16'd0;
                end
`endif
            end
            S_GAP: begin
                if ({1'b0, cnt_q} == ((idx_q == 2'd0) ? GAP_LAST_E0 : GAP_LAST)) begin
                    cnt_d = 16'd0;
                    if (idx_q == 2'd2) begin
                        state_d     = S_DONE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            S_ERR: begin
                cnt_d      = cnt_q;
                write_en_d = 1'b0;
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = 16'd0;
            end
        endcase

        if (start_rise) begin
            state_d     = S_PWRUP;
            cnt_d       = 16'd0;
            idx_d       = 2'd0;
            write_en_d  = 1'b0;
            init_done_d = 1'b0;
            err_d       = 1'b0;
        end

        busy_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    // State and registered outputs; reset clears the enable immediately to abort the engine.
    always_ff @(posedge i_mdc or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= 16'd0;
            idx_q       <= 2'd0;
            start_q     <= 1'b0;
            write_en_q  <= 1'b0;
            phy_ad_q    <= 5'd0;
            phyreg_ad_q <= 5'd0;
            phy_data_q  <= 16'd0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            start_q     <= bus.i_start;
            write_en_q  <= write_en_d;
            phy_ad_q    <= phy_ad_d;
            phyreg_ad_q <= phyreg_ad_d;
            phy_data_q  <= phy_data_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_write_en  = write_en_q;
    assign bus.o_phy_ad    = phy_ad_q;
    assign bus.o_phyreg_ad = phyreg_ad_q;
    assign bus.o_phy_data  = phy_data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_init_done = init_done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_phy_init_seq.sv
// tb_phy_init_seq: directed bench for phy_init_seq. Plays the write engine by
// hand: waits for o_write_en, holds the frame 64 cycles, returns one done pulse.
// Build with PHY_INIT_TIMEOUT_EN defined to also exercise the timeout path.
module tb_phy_init_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    phy_init_seq_if bus();

    phy_init_seq #(
        .PHY_AD      (5'h01),
        .PWRUP_CYC   (16'd10),
        .GAP_CYC     (8'd4),
`ifdef PHY_INIT_TIMEOUT_EN
        .TIMEOUT_CYC (16'd20),
`endif
        .RST_WAIT    (16'd20)
    ) dut (
        .i_mdc   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges until o_write_en rises; optionally pulse done at edge pulse_at.
    task automatic wait_rise(input string tag, input int exp_n, input int pulse_at,
                             input logic [15:0] exp_data);
        int          n;
        bit          seen;
        logic [15:0] prev_data;
        n = 400;
        seen = 1'b0;
        prev_data = 16'hxxxx;
        for (int k = 1; k <= 400 && !seen; k++) begin
            prev_data = bus.o_phy_data;
            bus.i_write_done = (k == pulse_at);
            tick();
            if (bus.o_write_en) begin
                seen = 1'b1;
                n = k;
            end
        end
        bus.i_write_done = 1'b0;
        check({tag, " rise_cycles"}, 32'(n), 32'(exp_n));
        check({tag, " data_before_en"}, 32'(prev_data), 32'(exp_data));
    endtask

    // Engine side of one frame: check the entry, hold 64 cycles, pulse done once.
    task automatic serve(input string tag, input logic [4:0] reg_e, input logic [15:0] dat_e);
        bit stable;
        stable = 1'b1;
        check({tag, " phy_ad"}, 32'(bus.o_phy_ad), 32'h01);
        check({tag, " reg"}, 32'(bus.o_phyreg_ad), 32'(reg_e));
        check({tag, " data"}, 32'(bus.o_phy_data), 32'(dat_e));
        check({tag, " busy"}, 32'(bus.o_busy), 32'h1);
        for (int k = 0; k < 62; k++) begin
            tick();
            if (!bus.o_write_en || bus.o_phyreg_ad !== reg_e ||
                bus.o_phy_data !== dat_e || bus.o_phy_ad !== 5'h01)
                stable = 1'b0;
        end
        check({tag, " stable"}, 32'(stable), 32'h1);
        bus.i_write_done = 1'b1;
        tick();
        bus.i_write_done = 1'b0;
        check({tag, " we_off_after_done"}, 32'(bus.o_write_en), 32'h0);
    endtask

    // Full three-entry run starting at the first edge of the power-up wait.
    task automatic run_seq(input string tag, input int pwr_pulse);
        wait_rise({tag, " pwrup"}, 12, pwr_pulse, 16'h8000);
        serve({tag, " e0"}, 5'h00, 16'h8000);
        wait_rise({tag, " gap0"}, 26, 5, 16'h01E1);
        serve({tag, " e1"}, 5'h04, 16'h01E1);
        wait_rise({tag, " gap1"}, 6, 2, 16'h1200);
        serve({tag, " e2"}, 5'h00, 16'h1200);
        repeat (3) tick();
        check({tag, " done_not_early"}, 32'(bus.o_init_done), 32'h0);
        check({tag, " busy_in_gap"}, 32'(bus.o_busy), 32'h1);
        tick();
        check({tag, " init_done"}, 32'(bus.o_init_done), 32'h1);
        check({tag, " busy_done"}, 32'(bus.o_busy), 32'h0);
        check({tag, " we_done"}, 32'(bus.o_write_en), 32'h0);
        check({tag, " data_hold"}, 32'(bus.o_phy_data), 32'h1200);
        check({tag, " err_done"}, 32'(bus.o_err), 32'h0);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_write_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst we", 32'(bus.o_write_en), 32'h0);
        check("rst phy_ad", 32'(bus.o_phy_ad), 32'h0);
        check("rst reg", 32'(bus.o_phyreg_ad), 32'h0);
        check("rst data", 32'(bus.o_phy_data), 32'h0);
        check("rst busy", 32'(bus.o_busy), 32'h0);
        check("rst init_done", 32'(bus.o_init_done), 32'h0);
        check("rst err", 32'(bus.o_err), 32'h0);

        // Reset release, done pulse during power-up is ignored.
        rst_n = 1'b1;
        run_seq("run1", 3);

        // Done pulse while in DONE changes nothing.
        bus.i_write_done = 1'b1;
        tick();
        bus.i_write_done = 1'b0;
        tick();
        check("done_pulse init_done", 32'(bus.o_init_done), 32'h1);
        check("done_pulse busy", 32'(bus.o_busy), 32'h0);
        check("done_pulse we", 32'(bus.o_write_en), 32'h0);

        // Restart, then abort entry 1 with start and done in the same cycle.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("restart init_done", 32'(bus.o_init_done), 32'h0);
        check("restart busy", 32'(bus.o_busy), 32'h1);
        wait_rise("run2 pwrup", 12, 0, 16'h8000);
        serve("run2 e0", 5'h00, 16'h8000);
        wait_rise("run2 gap0", 26, 0, 16'h01E1);
        repeat (10) tick();
        bus.i_start = 1'b1;
        bus.i_write_done = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_write_done = 1'b0;
        check("abort we", 32'(bus.o_write_en), 32'h0);
        check("abort busy", 32'(bus.o_busy), 32'h1);
        run_seq("run3", 0);

        // Asynchronous reset pulse in the middle of entry 0.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_rise("run4 pwrup", 12, 0, 16'h8000);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst we", 32'(bus.o_write_en), 32'h0);
        check("async_rst phy_ad", 32'(bus.o_phy_ad), 32'h0);
        check("async_rst data", 32'(bus.o_phy_data), 32'h0);
        check("async_rst busy", 32'(bus.o_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("run5", 0);

`ifdef PHY_INIT_TIMEOUT_EN
        // Engine never answers: ERR after 20 cycles in WRITE, then recover.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_rise("to pwrup", 12, 0, 16'h8000);
        repeat (18) tick();
        check("to pre err", 32'(bus.o_err), 32'h0);
        check("to pre we", 32'(bus.o_write_en), 32'h1);
        tick();
        check("to err", 32'(bus.o_err), 32'h1);
        check("to we", 32'(bus.o_write_en), 32'h0);
        check("to init_done", 32'(bus.o_init_done), 32'h0);
        check("to busy", 32'(bus.o_busy), 32'h0);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("to recover err", 32'(bus.o_err), 32'h0);
        run_seq("run6", 0);
`else
        check("err tied low", 32'(bus.o_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
